// File: rtl/wb_stage.sv
// Write-back stage of a 5-stage MIPS pipeline. It classifies the retiring instruction,
// waits for load data with a timeout, and issues one labelled register-file write.
module wb_stage #(
  parameter int LINK_OFFSET = 8,
  parameter int LD_TIMEOUT  = 15,
  parameter bit KEEP_R0     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] alu_res,
  input  logic [1:0]  addr_lo,
  input  logic        label_in,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_label,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_wlabel,
  output logic [2:0]  wb_sel,
  output logic        ld_err
);

  localparam logic [2:0]  SEL_ALU    = 3'b001;
  localparam logic [2:0]  SEL_LOAD   = 3'b010;
  localparam logic [2:0]  SEL_LINK   = 3'b100;
  localparam logic [5:0]  OP_SPECIAL = 6'h00;
  localparam logic [5:0]  OP_REGIMM  = 6'h01;
  localparam logic [5:0]  OP_JAL     = 6'h03;
  localparam logic [5:0]  OP_LB      = 6'h20;
  localparam logic [5:0]  OP_LH      = 6'h21;
  localparam logic [5:0]  OP_LW      = 6'h23;
  localparam logic [5:0]  OP_LBU     = 6'h24;
  localparam logic [5:0]  OP_LHU     = 6'h25;
  localparam logic [5:0]  FN_JALR    = 6'h09;
  localparam logic [4:0]  RT_BLTZAL  = 5'h10;
  localparam logic [4:0]  RT_BGEZAL  = 5'h11;
  localparam logic [7:0]  CNT_LAST   = 8'(LD_TIMEOUT - 1);
  localparam logic [31:0] LINK_OFF   = 32'(LINK_OFFSET);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;
  typedef enum logic [2:0] {CL_NONE, CL_LOAD, CL_LINK, CL_ALUR, CL_ALUI} cls_t;

  function automatic cls_t classify(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU}) return CL_LOAD;
    if (op == OP_JAL) return CL_LINK;
    if (op == OP_SPECIAL) return (ins[5:0] == FN_JALR) ? CL_LINK : CL_ALUR;
    if (op == OP_REGIMM && (ins[20:16] == RT_BLTZAL || ins[20:16] == RT_BGEZAL)) return CL_LINK;
    if (op[5:3] == 3'b001) return CL_ALUI;
    return CL_NONE;
  endfunction

  function automatic logic [4:0] dest(input logic [31:0] ins, input cls_t cls);
    if (ins[31:26] == OP_SPECIAL) return ins[15:11];
    if (cls == CL_LINK) return 5'd31;
    return ins[20:16];
  endfunction

  // Big-endian lanes: byte 0 is the most significant byte of the cache word.
  function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] lo,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = lo[1] ? w[15:0] : w[31:16];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic wr_allowed(input logic [4:0] a);
    return !(KEEP_R0 && a == 5'd0);
  endfunction

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [5:0]  op_q;
  logic [1:0]  lo_q;
  logic [4:0]  dst_q;
  logic        lbl_q;
  logic        rf_we_q, rf_wlabel_q, ld_err_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [2:0]  wb_sel_q;
  logic        accept;
  cls_t        cls_d;
  logic [4:0]  dst_d;

  assign in_ready = (state_q != WAIT);
  assign accept   = in_valid && in_ready;
  assign cls_d    = classify(instr);
  assign dst_d    = dest(instr, cls_d);

  // Load context only; needs no reset because it is consumed only after an acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= instr[31:26];
      lo_q  <= addr_lo;
      dst_q <= dst_d;
      lbl_q <= label_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rf_wlabel_q <= 1'b0;
      wb_sel_q    <= SEL_ALU;
      ld_err_q    <= 1'b0;
    end else begin
      rf_we_q  <= 1'b0;
      ld_err_q <= 1'b0;
      case (state_q)
        WAIT: begin
          if (ld_valid) begin
            state_q     <= WRITE;
            rf_we_q     <= wr_allowed(dst_q);
            rf_waddr_q  <= dst_q;
            rf_wdata_q  <= load_extract(op_q, lo_q, ld_data);
            rf_wlabel_q <= lbl_q | ld_label;
            wb_sel_q    <= SEL_LOAD;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= cnt_q + 8'd1;
            ld_err_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          if (accept) begin
            if (cls_d == CL_LOAD) begin
              state_q <= WAIT;
              cnt_q   <= '0;
            end else begin
              state_q     <= WRITE;
              rf_we_q     <= (cls_d != CL_NONE) && wr_allowed(dst_d);
              rf_waddr_q  <= dst_d;
              rf_wdata_q  <= (cls_d == CL_LINK) ? pc + LINK_OFF : alu_res;
              rf_wlabel_q <= label_in;
              wb_sel_q    <= (cls_d == CL_LINK) ? SEL_LINK : SEL_ALU;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_wlabel = rf_wlabel_q;
  assign wb_sel    = wb_sel_q;
  assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage: each instruction's expected write is derived from the
// MIPS decode rules with plain arithmetic, plus directed boundary cases.
module tb_wb_stage;

  localparam logic [2:0] SEL_ALU  = 3'b001;
  localparam logic [2:0] SEL_LOAD = 3'b010;
  localparam logic [2:0] SEL_LINK = 3'b100;
  localparam int         TMO      = 15;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, label_in = 1'b0, ld_valid = 1'b0, ld_label = 1'b0;
  logic [31:0] instr = '0, pc = '0, alu_res = '0, ld_data = '0;
  logic [1:0]  addr_lo = '0;
  logic        in_ready, rf_we, rf_wlabel, ld_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  wb_sel;

  int n_vec = 0;
  int n_err = 0;

  logic        last_ok;
  logic [4:0]  last_waddr;
  logic [31:0] last_wdata;
  logic [2:0]  last_sel;

  wb_stage #(.LINK_OFFSET(8), .LD_TIMEOUT(TMO), .KEEP_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .alu_res(alu_res), .addr_lo(addr_lo), .label_in(label_in),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_label(ld_label),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wlabel(rf_wlabel),
    .wb_sel(wb_sel), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    bit          is_none;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wlabel;
    logic [2:0]  sel;
  } exp_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Expected write-back of one instruction, straight from the ISA rules.
  function automatic exp_t ref_wb(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] a, input logic [1:0] lo, input logic lbl,
                                  input logic [31:0] ldd, input logic ldl);
    exp_t        e;
    int          op, rt, rd, fn, sh;
    logic [31:0] b, h;
    op = int'((ins >> 26) & 32'd63);
    rt = int'((ins >> 16) & 32'd31);
    rd = int'((ins >> 11) & 32'd31);
    fn = int'(ins & 32'd63);
    e.is_load = 1'b0;
    e.is_none = 1'b0;
    e.waddr   = 5'(rt);
    e.wdata   = a;
    e.wlabel  = lbl;
    e.sel     = SEL_ALU;
    if (op == 32 || op == 33 || op == 35 || op == 36 || op == 37) begin
      e.is_load = 1'b1;
      e.sel     = SEL_LOAD;
      e.wlabel  = lbl | ldl;
      sh = 8 * (3 - int'(lo));
      b  = (ldd >> sh) & 32'd255;
      h  = (lo >= 2'd2) ? (ldd & 32'hFFFF) : (ldd >> 16);
      case (op)
        32:      e.wdata = (b >= 32'd128) ? b - 32'd256 : b;
        36:      e.wdata = b;
        33:      e.wdata = (h >= 32'd32768) ? h - 32'd65536 : h;
        37:      e.wdata = h;
        default: e.wdata = ldd;
      endcase
    end else if (op == 3 || (op == 1 && (rt == 16 || rt == 17))) begin
      e.sel = SEL_LINK; e.waddr = 5'd31; e.wdata = p + 32'd8;
    end else if (op == 0) begin
      e.waddr = 5'(rd);
      if (fn == 9) begin e.sel = SEL_LINK; e.wdata = p + 32'd8; end
    end else if (!(op >= 8 && op <= 15)) begin
      e.is_none = 1'b1;
    end
    e.we = !e.is_none && (e.waddr != 5'd0);
    return e;
  endfunction

  task automatic check_hold(input string nm);
    check_eq({nm, ".sel_hold"}, wb_sel, last_sel);
    if (last_ok) begin
      check_eq({nm, ".waddr_hold"}, rf_waddr, last_waddr);
      check_eq({nm, ".wdata_hold"}, rf_wdata, last_wdata);
    end
  endtask

  // delay = WAIT cycle (1-based) on which ld_valid is raised; 0 or >TMO means never.
  task automatic xact(input string nm, input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] a, input logic [1:0] lo, input logic lbl,
                      input int delay, input logic [31:0] ldd, input logic ldl);
    exp_t e;
    bit   got;
    e = ref_wb(ins, p, a, lo, lbl, ldd, ldl);
    check_eq({nm, ".rdy"}, in_ready, 1);
    in_valid = 1'b1; instr = ins; pc = p; alu_res = a; addr_lo = lo; label_in = lbl;
    ld_valid = 1'($urandom_range(0, 1)); ld_data = $urandom; ld_label = 1'($urandom_range(0, 1));
    step();
    in_valid = 1'b0; ld_valid = 1'b0;
    instr = $urandom; pc = $urandom; alu_res = $urandom;
    addr_lo = 2'($urandom_range(0, 3)); label_in = 1'($urandom_range(0, 1));
    if (e.is_load) begin
      got = 1'b0;
      for (int k = 1; k <= TMO && !got; k++) begin
        check_eq({nm, ".wait_rdy"}, in_ready, 0);
        check_eq({nm, ".wait_we"}, rf_we, 0);
        if (k == delay) begin
          ld_valid = 1'b1; ld_data = ldd; ld_label = ldl; got = 1'b1;
        end else begin
          ld_data = $urandom; ld_label = 1'($urandom_range(0, 1));
        end
        step();
        ld_valid = 1'b0;
      end
      if (!got) begin
        check_eq({nm, ".ld_err"}, ld_err, 1);
        check_eq({nm, ".to_we"}, rf_we, 0);
        check_eq({nm, ".to_rdy"}, in_ready, 1);
        check_hold({nm, ".to"});
        step();
        check_eq({nm, ".ld_err_pulse"}, ld_err, 0);
        return;
      end
    end
    check_eq({nm, ".we"}, rf_we, e.we);
    check_eq({nm, ".ld_err0"}, ld_err, 0);
    check_eq({nm, ".sel"}, wb_sel, e.sel);
    if (!e.is_none) begin
      check_eq({nm, ".waddr"}, rf_waddr, e.waddr);
      check_eq({nm, ".wdata"}, rf_wdata, e.wdata);
      check_eq({nm, ".wlabel"}, rf_wlabel, e.wlabel);
      last_ok = 1'b1; last_waddr = e.waddr; last_wdata = e.wdata;
    end else begin
      last_ok = 1'b0;
    end
    last_sel = e.sel;
  endtask

  task automatic idle_cycle(input string nm);
    in_valid = 1'b0;
    ld_valid = 1'($urandom_range(0, 1)); ld_data = $urandom; ld_label = 1'($urandom_range(0, 1));
    step();
    ld_valid = 1'b0;
    check_eq({nm, ".we"}, rf_we, 0);
    check_eq({nm, ".ld_err"}, ld_err, 0);
    check_eq({nm, ".rdy"}, in_ready, 1);
    check_hold(nm);
  endtask

  task automatic check_reset_vals(input string nm);
    check_eq({nm, ".we"}, rf_we, 0);
    check_eq({nm, ".waddr"}, rf_waddr, 0);
    check_eq({nm, ".wdata"}, rf_wdata, 0);
    check_eq({nm, ".wlabel"}, rf_wlabel, 0);
    check_eq({nm, ".ld_err"}, ld_err, 0);
    check_eq({nm, ".sel"}, wb_sel, SEL_ALU);
    check_eq({nm, ".rdy"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    int          delay;
    logic [5:0]  ld_ops [5];
    ld_ops[0] = 6'h20; ld_ops[1] = 6'h21; ld_ops[2] = 6'h23; ld_ops[3] = 6'h24; ld_ops[4] = 6'h25;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    last_ok = 1'b1; last_waddr = '0; last_wdata = '0; last_sel = SEL_ALU;
    step();
    check_eq("post_reset.rdy", in_ready, 1);

    xact("addu", mk_r(5'd1, 5'd2, 5'd5, 6'h21), 32'h100, 32'h00001234, 2'd0, 1'b0, 0, '0, 1'b0);
    check_eq("addu.k_waddr", rf_waddr, 5);
    check_eq("addu.k_wdata", rf_wdata, 32'h00001234);
    check_eq("addu.k_we", rf_we, 1);
    idle_cycle("idle1");

    xact("lb", mk_i(6'h20, 5'd3, 5'd7, 16'h0), 32'h104, 32'h0, 2'd2, 1'b0, 3, 32'h11228344, 1'b0);
    check_eq("lb.k_wdata", rf_wdata, 32'hFFFFFF83);
    check_eq("lb.k_waddr", rf_waddr, 7);
    idle_cycle("idle2");

    xact("jal", {6'h03, 26'h0000123}, 32'h00000400, $urandom, 2'd0, 1'b1, 0, '0, 1'b0);
    check_eq("jal.k_wdata", rf_wdata, 32'h00000408);
    check_eq("jal.k_waddr", rf_waddr, 31);
    check_eq("jal.k_sel", wb_sel, SEL_LINK);
    xact("bltzal", mk_i(6'h01, 5'd4, 5'h10, 16'hFFF0), 32'h00000400, $urandom, 2'd0, 1'b0, 0, '0, 1'b0);
    check_eq("bltzal.k_wdata", rf_wdata, 32'h00000408);
    check_eq("bltzal.k_waddr", rf_waddr, 31);

    xact("addu_r0", mk_r(5'd1, 5'd2, 5'd0, 6'h21), 32'h200, 32'h55, 2'd0, 1'b0, 0, '0, 1'b0);
    xact("sw", mk_i(6'h2B, 5'd1, 5'd9, 16'h10), 32'h204, 32'h66, 2'd0, 1'b0, 0, '0, 1'b0);
    xact("beq", mk_i(6'h04, 5'd1, 5'd2, 16'h8), 32'h208, 32'h77, 2'd0, 1'b0, 0, '0, 1'b0);
    xact("b2b_addu", mk_r(5'd1, 5'd2, 5'd3, 6'h21), 32'h20C, 32'h88, 2'd0, 1'b1, 0, '0, 1'b0);
    idle_cycle("idle3");

    xact("lhu_to", mk_i(6'h25, 5'd1, 5'd6, 16'h0), 32'h300, 32'h0, 2'd2, 1'b0, 0, 32'hA5A5A5A5, 1'b1);
    idle_cycle("idle4");

    check_eq("rst_wait.pre_rdy", in_ready, 1);
    in_valid = 1'b1; instr = mk_i(6'h23, 5'd1, 5'd9, 16'h0); label_in = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    ld_label = 1'b1; ld_data = 32'hDEADBEEF;
    #3 rst_n = 1'b0;
    #1 check_reset_vals("rst_wait");
    step();
    rst_n = 1'b1;
    last_ok = 1'b1; last_waddr = '0; last_wdata = '0; last_sel = SEL_ALU;
    ld_valid = 1'b1;
    step();
    check_eq("rst_wait.no_we1", rf_we, 0);
    step();
    check_eq("rst_wait.no_we2", rf_we, 0);
    ld_valid = 1'b0;
    ld_label = 1'b0;

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0: ins = mk_r(5'($urandom), 5'($urandom), ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                      ($urandom_range(0, 3) == 0) ? 6'h09 : 6'($urandom));
        1: ins = mk_i(6'($urandom_range(8, 15)), 5'($urandom), 5'($urandom), 16'($urandom));
        2, 3: begin
          op  = ld_ops[$urandom_range(0, 4)];
          ins = mk_i(op, 5'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 16'($urandom));
        end
        4: ins = {6'h03, 26'($urandom)};
        5: ins = mk_i(6'h01, 5'($urandom), 5'($urandom_range(15, 18)), 16'($urandom));
        6: ins = mk_i(($urandom_range(0, 1) == 1) ? 6'h2B : 6'h04, 5'($urandom), 5'($urandom), 16'($urandom));
        default: ins = $urandom;
      endcase
      delay = $urandom_range(1, TMO + 2);
      xact("rand", ins, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           delay, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycle("rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter LINK_OFFSET, default 8, the value added to the captured PC to form the link value.
REQ-002 The block SHALL have parameter LD_TIMEOUT, default 15, the maximum number of WAIT cycles before a load is abandoned (1..255).
REQ-003 The block SHALL have parameter KEEP_R0, default 1; when 1, writes to register 0 are suppressed.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the MEM stage offers an instruction.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the instruction this cycle.
REQ-008 The block SHALL have port instr, input, 32 bits: the stage-5 MIPS instruction.
REQ-009 The block SHALL have port pc, input, 32 bits: the PC of instr.
REQ-010 The block SHALL have port alu_res, input, 32 bits: the ALU result.
REQ-011 The block SHALL have port addr_lo, input, 2 bits: the load byte offset.
REQ-012 The block SHALL have port label_in, input, 1 bit: the instruction security label.
REQ-013 The block SHALL have port ld_valid, input, 1 bit: ld_data is valid this cycle.
REQ-014 The block SHALL have port ld_data, input, 32 bits: the aligned cache word.
REQ-015 The block SHALL have port ld_label, input, 1 bit: the label of the loaded data.
REQ-016 The block SHALL have port rf_we, output, 1 bit: the register-file write enable.
REQ-017 The block SHALL have port rf_waddr, output, 5 bits: the destination register.
REQ-018 The block SHALL have port rf_wdata, output, 32 bits: the write-back value.
REQ-019 The block SHALL have port rf_wlabel, output, 1 bit: the label of the write.
REQ-020 The block SHALL have port wb_sel, output, 3 bits: `select_wb_load, `select_wb_link or `select_wb_alu (mips.h encodings).
REQ-021 The block SHALL have port ld_err, output, 1 bit: a one-cycle pulse on load timeout.

Function
REQ-022 The block SHALL use the FSM states IDLE, WAIT, WRITE; in_ready SHALL be 1 in IDLE and WRITE and 0 in WAIT.
REQ-023 The block SHALL accept an instruction on in_valid && in_ready and capture instr, pc, alu_res, addr_lo and label_in.
REQ-024 On acceptance the block SHALL classify the instruction as LOAD (LB, LBU, LH, LHU, LW), LINK (JAL; SPECIAL/JALR; REGIMM with rt = BGEZAL or BLTZAL), ALU_R (SPECIAL, not JALR), ALU_I (op 001xxx) or NONE (everything else).
REQ-025 After acceptance the block SHALL go to WAIT for a LOAD and to WRITE for any other class.
REQ-026 In WAIT, when ld_valid=1, the block SHALL register the extracted load value and label_in|ld_label, then go to WRITE.
REQ-027 The block SHALL ignore ld_valid in IDLE and WRITE.
REQ-028 In WAIT, a counter SHALL increment each cycle while ld_valid=0.
REQ-029 When the WAIT counter reaches LD_TIMEOUT, the block SHALL pulse ld_err for one cycle, perform no write and go to IDLE.
REQ-030 The WAIT counter SHALL clear on every entry to WAIT.
REQ-031 The block SHALL use big-endian byte lanes: byte k occupies bits [31-8k:24-8k]; halfword addr_lo[1] selects bits [31:16] (0) or [15:0] (1); addr_lo[0] SHALL be ignored for halfwords.
REQ-032 LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL pass the full word.
REQ-033 For LINK, rf_wdata SHALL be pc+LINK_OFFSET modulo 2^32.
REQ-034 For ALU_R and ALU_I, rf_wdata SHALL be alu_res.
REQ-035 rf_waddr SHALL be rt for LOAD and ALU_I, 31 for JAL and REGIMM links, and rd for SPECIAL.
REQ-036 In WRITE, rf_we SHALL be 1 for exactly one cycle, except that it SHALL be 0 for class NONE or when KEEP_R0=1 and rf_waddr=0.
REQ-037 In WRITE, rf_waddr, rf_wdata, rf_wlabel and wb_sel SHALL be valid.
REQ-038 For non-loads, rf_wlabel SHALL be label_in.
REQ-039 wb_sel SHALL be load for LOAD, link for LINK, and alu otherwise.
REQ-040 An acceptance in WRITE SHALL follow REQ-025 (back-to-back non-loads at 1 per cycle); with no acceptance, WRITE SHALL go to IDLE.
REQ-041 Outside WRITE, rf_we SHALL be 0; rf_waddr, rf_wdata and wb_sel SHALL hold their last values.

Reset
REQ-042 rst_n=0 SHALL asynchronously force IDLE, clear the WAIT counter, and drive rf_we=0, rf_waddr=0, rf_wdata=0, rf_wlabel=0, ld_err=0 and wb_sel=`select_wb_alu.
REQ-043 in_ready SHALL be 1 after reset.
REQ-044 Reset during WAIT or WRITE SHALL abandon the instruction with no write.

Verification
REQ-045 The bench SHALL check: ADDU rd=5 with alu_res=0x00001234 accepted -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234, wb_sel=alu.
REQ-046 The bench SHALL check: LB rt=7, addr_lo=2, ld_data=0x11228344 with ld_valid 3 cycles later -> in_ready=0 for 3 cycles, then rf_wdata=0xFFFFFF83, rf_waddr=7.
REQ-047 The bench SHALL check: JAL at pc=0x00000400, and BLTZAL -> rf_waddr=31, rf_wdata=0x00000408, wb_sel=link.
REQ-048 The bench SHALL check: ADDU rd=0, SW and BEQ -> rf_we stays 0, and back-to-back acceptance proceeds at 1 per cycle.
REQ-049 The bench SHALL check: LHU with no ld_valid -> after 15 WAIT cycles, ld_err=1 for one cycle, no write, in_ready=1.
REQ-050 The bench SHALL check: rst_n low during WAIT with ld_label=1 pending -> all outputs at reset values, and ld_valid afterward causes no write.
